// File: rtl/counter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | counter_pkg: shared state encoding and counter next-value function |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package counter_pkg;

  localparam int DEF_WIDTH = 3;
  localparam int NEXT_W    = 32;

  typedef enum logic [1:0] {
    SYNC  = 2'd0,
    TRACK = 2'd1,
    FAIL  = 2'd2
  } state_e;

  // Callers zero-extend into NEXT_W and truncate the result back to their own
  // width; truncation gives the mod 2^WIDTH wrap for free.
  function automatic logic [NEXT_W-1:0] next_val(
    input logic              ld,
    input logic              inc,
    input logic [NEXT_W-1:0] data_in,
    input logic [NEXT_W-1:0] cur
  );
    if (ld) begin
      return data_in;
    end else if (inc) begin
      return cur + NEXT_W'(1);
    end else begin
      return cur;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter_monitor_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | counter_monitor_if: control/output bus of the loadable up-counter   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
interface counter_monitor_if #(
  parameter int WIDTH = 3
) ();

  logic             ld;
  logic             inc;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;

  modport master (
    output ld,
    output inc,
    output data_in,
    output data_out
  );

  modport slave (
    input ld,
    input inc,
    input data_in,
    input data_out
  );

endinterface
`default_nettype wire

// File: rtl/counter_ref_model.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | counter_ref_model: cycle-accurate model of the up-counter value     |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module counter_ref_model
  import counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             ld,
  input  wire logic             inc,
  input  wire logic [WIDTH-1:0] data_in,
  input  wire logic [WIDTH-1:0] data_out,
  input  wire logic             load_obs,
  output logic      [WIDTH-1:0] expected
);

  logic [WIDTH-1:0] expected_q;
  logic [WIDTH-1:0] expected_d;
  logic [WIDTH-1:0] base_val;

  // load_obs re-seeds the model from the observed counter instead of itself
  always_comb begin
    base_val   = load_obs ? data_out : expected_q;
    expected_d = WIDTH'(next_val(ld, inc, NEXT_W'(data_in), NEXT_W'(base_val)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      expected_q <= '0;
    end else begin
      expected_q <= expected_d;
    end
  end

  assign expected = expected_q;

endmodule
`default_nettype wire

// File: rtl/counter_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | counter_monitor: passive checker for the loadable up-counter        |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module counter_monitor
  import counter_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int ERR_CNT_W   = 8,
  parameter int STOP_ON_ERR = 0
) (
  input  wire logic                 clk,
  input  wire logic                 rst,
  counter_monitor_if.slave          bus,
  input  wire logic                 clr_err,
  output logic      [WIDTH-1:0]     expected,
  output logic                      mismatch,
  output logic                      err_sticky,
  output logic      [ERR_CNT_W-1:0] err_count,
  output logic                      wrap_pulse,
  output logic      [1:0]           state
);

  state_e               state_q,      state_d;
  logic                 mismatch_q,   mismatch_d;
  logic                 err_sticky_q, err_sticky_d;
  logic [ERR_CNT_W-1:0] err_count_q,  err_count_d;
  logic                 wrap_pulse_q, wrap_pulse_d;
  logic                 load_obs;
  logic                 err;
  logic [WIDTH-1:0]     model_val;

  counter_ref_model #(
    .WIDTH (WIDTH)
  ) u_ref_model (
    .clk      (clk),
    .rst      (rst),
    .ld       (bus.ld),
    .inc      (bus.inc),
    .data_in  (bus.data_in),
    .data_out (bus.data_out),
    .load_obs (load_obs),
    .expected (model_val)
  );

  // Case-inequality so an X/Z on data_out is reported as a mismatch
  assign err = (bus.data_out !== model_val);

  always_comb begin
    state_d      = state_q;
    mismatch_d   = 1'b0;
    err_sticky_d = err_sticky_q;
    err_count_d  = err_count_q;
    wrap_pulse_d = 1'b0;
    load_obs     = 1'b1;

    case (state_q)
      SYNC: begin
        state_d = TRACK;
      end
      TRACK: begin
        load_obs     = 1'b0;
        wrap_pulse_d = (&model_val) && bus.inc && !bus.ld;
        if (err) begin
          mismatch_d   = 1'b1;
          err_sticky_d = 1'b1;
          if (err_count_q != '1) begin
            err_count_d = err_count_q + ERR_CNT_W'(1);
          end
          if (STOP_ON_ERR != 0) begin
            state_d = FAIL;
          end
        end
      end
      FAIL: begin
        state_d = FAIL;
      end
      default: begin
        state_d = SYNC;
      end
    endcase

    // A clear discards whatever the compare found this cycle
    if (clr_err) begin
      state_d      = SYNC;
      mismatch_d   = 1'b0;
      err_sticky_d = 1'b0;
      err_count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SYNC;
      mismatch_q   <= 1'b0;
      err_sticky_q <= 1'b0;
      err_count_q  <= '0;
      wrap_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mismatch_q   <= mismatch_d;
      err_sticky_q <= err_sticky_d;
      err_count_q  <= err_count_d;
      wrap_pulse_q <= wrap_pulse_d;
    end
  end

  assign expected   = model_val;
  assign mismatch   = mismatch_q;
  assign err_sticky = err_sticky_q;
  assign err_count  = err_count_q;
  assign wrap_pulse = wrap_pulse_q;
  assign state      = state_q;

endmodule
`default_nettype wire

// File: tb/tb_counter_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_counter_monitor: scoreboard bench for three monitor configs      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_counter_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       clr_err;
  logic       ld;
  logic       inc;
  logic [2:0] din;
  logic [2:0] cnt;
  logic       force_en;
  logic [2:0] force_val;

  always #5 clk = ~clk;

  // Stand-in for the real counter; force_* overrides its output to inject faults
  always @(posedge clk) begin
    if (rst)      cnt <= 3'd0;
    else if (ld)  cnt <= din;
    else if (inc) cnt <= cnt + 3'd1;
  end

  counter_monitor_if #(.WIDTH(3)) bus ();
  assign bus.ld       = ld;
  assign bus.inc      = inc;
  assign bus.data_in  = din;
  assign bus.data_out = force_en ? force_val : cnt;

  // dut0: defaults; dut1: STOP_ON_ERR=1; dut2: ERR_CNT_W=2
  logic [2:0] exp_o   [3];
  logic       mis_o   [3];
  logic       stk_o   [3];
  logic       wrap_o  [3];
  logic [1:0] st_o    [3];
  logic [7:0] cnt_a   [3];
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  assign cnt_a[0] = cnt0;
  assign cnt_a[1] = cnt1;
  assign cnt_a[2] = {6'd0, cnt2};

  counter_monitor #(.WIDTH(3), .ERR_CNT_W(8), .STOP_ON_ERR(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus), .clr_err(clr_err), .expected(exp_o[0]),
    .mismatch(mis_o[0]), .err_sticky(stk_o[0]), .err_count(cnt0),
    .wrap_pulse(wrap_o[0]), .state(st_o[0]));
  counter_monitor #(.WIDTH(3), .ERR_CNT_W(8), .STOP_ON_ERR(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus), .clr_err(clr_err), .expected(exp_o[1]),
    .mismatch(mis_o[1]), .err_sticky(stk_o[1]), .err_count(cnt1),
    .wrap_pulse(wrap_o[1]), .state(st_o[1]));
  counter_monitor #(.WIDTH(3), .ERR_CNT_W(2), .STOP_ON_ERR(0)) dut2 (
    .clk(clk), .rst(rst), .bus(bus), .clr_err(clr_err), .expected(exp_o[2]),
    .mismatch(mis_o[2]), .err_sticky(stk_o[2]), .err_count(cnt2),
    .wrap_pulse(wrap_o[2]), .state(st_o[2]));

  typedef struct {
    logic [2:0] exp_v;
    logic       mis;
    logic       wrap;
    logic [7:0] cnt;
    logic [1:0] st;
  } sb_t;

  sb_t        sbq[$];
  int         checks = 0;
  int         passed = 0;
  logic [2:0] m_exp;
  logic       m_sync;
  logic [7:0] m_cnt;

  // Apply one cycle of stimulus to dut0's scoreboard, then compare its outputs
  task automatic drive(input logic l, input logic i, input logic [2:0] d, input logic c);
    sb_t        e;
    logic [2:0] dout;
    logic [2:0] base;
    ld = l; inc = i; din = d; clr_err = c;
    dout    = force_en ? force_val : cnt;
    base    = m_sync ? dout : m_exp;
    e.exp_v = l ? d : (i ? base + 3'd1 : base);
    e.mis   = !m_sync && !c && (dout !== m_exp);
    e.wrap  = !m_sync && (m_exp == 3'd7) && i && !l;
    e.cnt   = c ? 8'd0 : (e.mis ? m_cnt + 8'd1 : m_cnt);
    e.st    = c ? 2'd0 : 2'd1;
    sbq.push_back(e);
    m_exp = e.exp_v; m_sync = c; m_cnt = e.cnt;
    @(posedge clk); #1;
    e = sbq.pop_front();
    checks++; if (exp_o[0] !== e.exp_v) $display("FAIL sb_expected got=%0d want=%0d", exp_o[0], e.exp_v); else passed++;
    checks++; if (mis_o[0] !== e.mis) $display("FAIL sb_mismatch got=%0b want=%0b", mis_o[0], e.mis); else passed++;
    checks++; if (wrap_o[0] !== e.wrap) $display("FAIL sb_wrap got=%0b want=%0b", wrap_o[0], e.wrap); else passed++;
    checks++; if (cnt_a[0] !== e.cnt) $display("FAIL sb_err_count got=%0d want=%0d", cnt_a[0], e.cnt); else passed++;
    checks++; if (st_o[0] !== e.st) $display("FAIL sb_state got=%0d want=%0d", st_o[0], e.st); else passed++;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr_err = 1'b0; ld = 1'b0; inc = 1'b0; din = 3'd0;
    force_en = 1'b0; force_val = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (st_o[k] !== 2'd0) $display("FAIL reset_state dut%0d got=%0d want=0", k, st_o[k]); else passed++;
      checks++; if (exp_o[k] !== 3'd0) $display("FAIL reset_expected dut%0d got=%0d want=0", k, exp_o[k]); else passed++;
      checks++; if ({mis_o[k], stk_o[k], wrap_o[k]} !== 3'b000) $display("FAIL reset_flags dut%0d got=%b want=000", k, {mis_o[k], stk_o[k], wrap_o[k]}); else passed++;
      checks++; if (cnt_a[k] !== 8'd0) $display("FAIL reset_err_count dut%0d got=%0d want=0", k, cnt_a[k]); else passed++;
    end
    rst = 1'b0;
    m_exp = 3'd0; m_sync = 1'b1; m_cnt = 8'd0;
    drive(1'b0, 1'b0, 3'd0, 1'b0);
  endtask

  task automatic test_count_wrap();
    int wraps = 0;
    for (int n = 0; n < 10; n++) begin
      drive(1'b0, 1'b1, 3'd0, 1'b0);
      if (wrap_o[0] === 1'b1) wraps++;
    end
    checks++; if (wraps !== 1) $display("FAIL wrap_once got=%0d want=1", wraps); else passed++;
    checks++; if (exp_o[0] !== 3'd2) $display("FAIL walk_end got=%0d want=2", exp_o[0]); else passed++;
    checks++; if (cnt_a[0] !== 8'd0) $display("FAIL walk_err_count got=%0d want=0", cnt_a[0]); else passed++;
  endtask

  task automatic test_ld_priority();
    drive(1'b1, 1'b1, 3'd5, 1'b0);
    checks++; if (exp_o[0] !== 3'd5) $display("FAIL ld_priority got=%0d want=5", exp_o[0]); else passed++;
    drive(1'b1, 1'b1, 3'd7, 1'b0);
    drive(1'b1, 1'b1, 3'd0, 1'b0);
    checks++; if (wrap_o[0] !== 1'b0) $display("FAIL ld_zero_no_wrap got=%0b want=0", wrap_o[0]); else passed++;
  endtask

  task automatic test_single_fault();
    drive(1'b1, 1'b0, 3'd4, 1'b0);
    force_en = 1'b1; force_val = 3'd2;
    drive(1'b0, 1'b0, 3'd0, 1'b0);
    checks++; if (stk_o[0] !== 1'b1) $display("FAIL fault_sticky got=%0b want=1", stk_o[0]); else passed++;
    checks++; if (st_o[1] !== 2'd2) $display("FAIL stop_state got=%0d want=2", st_o[1]); else passed++;
    checks++; if (cnt_a[1] !== 8'd1) $display("FAIL stop_count got=%0d want=1", cnt_a[1]); else passed++;
    force_val = 3'd3;
    drive(1'b0, 1'b0, 3'd0, 1'b0);
    checks++; if (cnt_a[1] !== 8'd1) $display("FAIL stop_no_incr got=%0d want=1", cnt_a[1]); else passed++;
    checks++; if (mis_o[1] !== 1'b0) $display("FAIL stop_no_mismatch got=%0b want=0", mis_o[1]); else passed++;
    checks++; if (exp_o[1] !== 3'd3) $display("FAIL stop_follow got=%0d want=3", exp_o[1]); else passed++;
    force_en = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 1'b0);
    checks++; if (stk_o[0] !== 1'b1) $display("FAIL sticky_hold got=%0b want=1", stk_o[0]); else passed++;
    drive(1'b0, 1'b0, 3'd0, 1'b1);
    checks++; if (st_o[1] !== 2'd0) $display("FAIL clr_state got=%0d want=0", st_o[1]); else passed++;
    checks++; if ({stk_o[1], cnt_a[1]} !== 9'd0) $display("FAIL clr_stats got=%0d want=0", {stk_o[1], cnt_a[1]}); else passed++;
    drive(1'b0, 1'b0, 3'd0, 1'b0);
    checks++; if (st_o[1] !== 2'd1) $display("FAIL clr_track got=%0d want=1", st_o[1]); else passed++;
  endtask

  task automatic test_saturate();
    drive(1'b1, 1'b0, 3'd1, 1'b0);
    force_en = 1'b1; force_val = 3'd0;
    repeat (6) drive(1'b0, 1'b1, 3'd0, 1'b0);
    checks++; if (cnt_a[2] !== 8'd3) $display("FAIL sat_count got=%0d want=3", cnt_a[2]); else passed++;
    checks++; if (stk_o[2] !== 1'b1) $display("FAIL sat_sticky got=%0b want=1", stk_o[2]); else passed++;
  endtask

  task automatic test_rst_with_clr();
    rst = 1'b1; clr_err = 1'b1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      checks++; if (st_o[k] !== 2'd0) $display("FAIL rst_clr_state dut%0d got=%0d want=0", k, st_o[k]); else passed++;
      checks++; if (exp_o[k] !== 3'd0) $display("FAIL rst_clr_expected dut%0d got=%0d want=0", k, exp_o[k]); else passed++;
      checks++; if ({mis_o[k], stk_o[k], wrap_o[k]} !== 3'b000) $display("FAIL rst_clr_flags dut%0d got=%b want=000", k, {mis_o[k], stk_o[k], wrap_o[k]}); else passed++;
      checks++; if (cnt_a[k] !== 8'd0) $display("FAIL rst_clr_err_count dut%0d got=%0d want=0", k, cnt_a[k]); else passed++;
    end
    rst = 1'b0; force_en = 1'b0;
    m_exp = 3'd0; m_sync = 1'b1; m_cnt = 8'd0;
    drive(1'b0, 1'b1, 3'd0, 1'b0);
    for (int k = 1; k < 3; k++) begin
      checks++; if (st_o[k] !== 2'd1) $display("FAIL rst_then_track dut%0d got=%0d want=1", k, st_o[k]); else passed++;
    end
    repeat (3) drive(1'b0, 1'b1, 3'd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_count_wrap();
    test_ld_priority();
    test_single_fault();
    test_saturate();
    test_rst_with_clr();
    checks++; if (sbq.size() !== 0) $display("FAIL sb_drain got=%0d want=0", sbq.size()); else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/counter_monitor.md
Name: counter_monitor

Overview:
- Passive checker on the control/output interface of the loadable up-counter (`threebitcounter`), i.e. the reader end of that interface.
- Observes `ld`/`inc`/`data_in` and the counter's registered `data_out`, and keeps a cycle-accurate reference model of the counter.
- Flags mismatches, counts errors and reports model wrap-around.
- Instantiated alongside the counter in benches and, optionally, in synthesised debug builds.

Parameters:
- WIDTH, 3, counter data width.
- ERR_CNT_W, 8, width of the saturating error counter.
- STOP_ON_ERR, 0, 1 = enter FAIL on first mismatch and stop comparing; 0 = keep checking.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- ld  input  1  counter load strobe, as driven to the counter.
- inc  input  1  counter increment strobe, as driven to the counter.
- data_in  input  WIDTH  counter load value.
- data_out  input  WIDTH  counter registered output under check.
- clr_err  input  1  synchronous clear of error state and counter.
- expected  output  WIDTH  model's predicted counter value for the current cycle.
- mismatch  output  1  one-cycle pulse: previous cycle's compare failed.
- err_sticky  output  1  set on any mismatch; held until clr_err or rst.
- err_count  output  ERR_CNT_W  number of mismatches, saturating at all-ones.
- wrap_pulse  output  1  one-cycle pulse: model wrapped from all-ones to 0 via inc.
- state  output  2  current FSM state, for debug.

Behaviour:
- Counter semantics modelled:
  - rst gives 0.
  - ld has priority over inc: next = data_in.
  - Otherwise inc gives next = cur+1 mod 2^WIDTH.
  - Otherwise next = cur.
- next(x) denotes that function applied to x with the current ld/inc/data_in.
- Reset (rst=1 at posedge): state=SYNC, expected=0, mismatch=0, err_sticky=0, err_count=0, wrap_pulse=0. rst overrides clr_err and every other input.
- FSM states: SYNC=2'd0, TRACK=2'd1, FAIL=2'd2; 2'd3 is illegal and recovers to SYNC on the next edge.
- SYNC:
  - Lasts exactly one cycle, with no compare.
  - expected <= next(data_out), i.e. the model adopts the observed value, so independent reset of monitor and counter is tolerated.
  - Transitions to TRACK.
- TRACK, at each posedge:
  - Compare: err = (data_out != expected).
  - mismatch <= err.
  - If err: err_sticky <= 1 and err_count increments unless already saturated.
  - expected <= next(expected). The model does not resync on error, so persistent faults produce one mismatch per cycle.
  - If err and STOP_ON_ERR=1, go to FAIL; else stay in TRACK.
- FAIL:
  - No compare; mismatch=0.
  - expected <= next(data_out), so the model follows the DUT.
  - Leaves only via clr_err or rst.
- clr_err (rst=0):
  - err_sticky <= 0, err_count <= 0, mismatch <= 0; state goes to SYNC from any state.
  - The compare result in a clr_err cycle is discarded, so clr_err wins over a simultaneous mismatch.
- wrap_pulse:
  - Asserted the cycle after an edge where expected was all-ones, inc=1 and ld=0, in TRACK only.
  - ld of 0 while at all-ones is not a wrap.
- Latency: mismatch and err_sticky rise 1 cycle after the offending data_out is present.
- Outputs are all registered; no combinational input-to-output path.
- X/Z on data_out counts as a mismatch (use case-inequality in simulation builds).

Decomposition:
- Shared package counter_pkg holds:
  - state encoding constants SYNC/TRACK/FAIL;
  - default WIDTH=3;
  - a next-value function (ld, inc, data_in, cur) reused by the counter's own model and future counter variants.
- One sub-module is natural: counter_ref_model, holding the expected register and next-value logic, with load-from-observed control. The FSM, compare and statistics stay in the top level.

Test Plan:
- Reset, then ld=0, inc=1 for 10 cycles against a correct counter -> expected walks 0..7,0,1; mismatch stays 0; wrap_pulse high exactly once, the cycle after 7→0; err_count=0.
- ld=1, data_in=3'd5 with inc=1 simultaneously -> expected=5 next cycle (ld priority); no wrap_pulse; no mismatch.
- Force data_out=3'd2 when expected=3'd4 for one cycle, STOP_ON_ERR=0 -> mismatch pulses one cycle later; err_sticky=1; err_count=1; checking continues.
- STOP_ON_ERR=1, inject a fault -> state=FAIL; subsequent faults do not increment err_count; clr_err -> state=SYNC, then TRACK; err_sticky=0, err_count=0.
- ERR_CNT_W=2, stuck-at-0 data_out for 6 cycles while incrementing -> err_count saturates at 3; err_sticky=1.
- Assert rst mid-TRACK with err_sticky=1, together with clr_err -> all outputs reach reset values at that edge; state=SYNC, then TRACK after one cycle.
